blake512_msg_loader: RTL and testbench
======================================

Name: blake512_msg_loader

Overview:
Upstream feeder for the BLAKE-512 round controller/core. Accepts the message as a stream of 64-bit big-endian words and buffers them into 16-word (1024-bit) blocks. Applies BLAKE-512 padding (0x80 marker, 0x01 terminator bit, 128-bit bit-length) and computes the per-block counter t. It then pulses the core's enable and holds the block stable until the core reports finalize.

Parameters:
LEN_W, 64, width of internal message bit-length accumulator; upper 128-LEN_W bits of length field and blk_t are zero
NWORDS, 16, words per block (fixed by algorithm; not for override)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
in_valid  in  1  input word valid
in_ready  out  1  loader can accept a word this cycle
in_data  in  64  message word, byte 0 = bits [63:56]
in_last  in  1  final word of message
in_bytes  in  4  valid bytes in final word, 0..8 (0 only legal with in_last; ignored unless in_last)
blk_valid  out  1  one-cycle start pulse to core (drives controller ena)
blk_m  out  1024  block, word 0 = bits [1023:960]
blk_t  out  128  counter t for this block
blk_last  out  1  this block is the final block of the message
core_done  in  1  core finished block (controller ctrl_finalize)
busy  out  1  high whenever state != FILL

Behaviour:
- Reset (sync, rst=1 at clk edge): state=FILL, word count=0, length=0, blk_valid=0, blk_m=0, blk_t=0, blk_last=0, in_ready=1 after the edge. Reset mid-block or mid-core-run discards everything; core_done is ignored until the next issued block.
- States: FILL, PAD, PAD2, ISSUE, WAIT.
- FILL: in_ready=1; transfer on in_valid&in_ready. Full word: store at word index, length += 64, idx++. Non-last word at idx 15 -> ISSUE (t=length, blk_last=0). in_last word -> store masked word (bytes >= in_bytes zeroed), length += 8*in_bytes, -> PAD.
- PAD (one cycle, in_ready=0): let B = byte offset of message end within block (idx*8+in_bytes, or 128 if the last word filled word 15 with 8 bytes). Zero all bytes after the message.
  - B<=111: byte B |= 0x80; byte 111 |= 0x01 (B=111 gives 0x81); words 14..15 = {zero-extended length}; t = length if block holds >=1 message byte, else 0; blk_last=1; -> ISSUE.
  - 112<=B<=127: byte B = 0x80; t=length; blk_last=0; -> ISSUE, then after WAIT -> PAD2.
  - B=128: no pad in this block; t=length; blk_last=0; -> ISSUE, then PAD2 with marker at byte 0.
- PAD2: block = zeros, byte 0 = 0x80 only if marker not yet placed; byte 111 |= 0x01; length field; t=0; blk_last=1; -> ISSUE.
- ISSUE: blk_valid=1 for exactly one cycle; -> WAIT.
- WAIT: in_ready=0; blk_m/blk_t/blk_last held. On core_done: after a last block -> FILL with length=0, idx=0; after a full non-last block -> FILL with idx=0, length kept; after a pad-overflow block -> PAD2.
- core_done in FILL/PAD/ISSUE is ignored. A core_done pulse coincident with ISSUE cannot occur; the core needs >=128 cycles.
- Latency: accepting word 15 -> blk_valid on the next cycle. Accepting the last word -> PAD -> blk_valid 2 cycles after the transfer.
- Length wraps modulo 2^LEN_W; no overflow flag.

Optional Feature:
LOADER_BSWAP_EN: when defined, in_data is little-endian per word. Bytes are reversed on input, and in_bytes counts valid bytes from bits [7:0] upward. Masking and padding then follow the normal big-endian path. When undefined, there is no swap logic and behaviour is exactly as above.

Decomposition:
- Shared package (blake512_pkg): block width 1024, word width 64, NWORDS=16, pad marker 8'h80, terminator 8'h01, terminator byte index 111, length-field word indices 14..15, state encoding localparams.
- One natural sub-module: blake512_pad_gen. It is combinational: takes the block, B, length, and marker/terminator flags, and returns the padded block.

Test Plan:
- Empty message (in_last, in_bytes=0) -> one block: word0=0x8000000000000000, word13=0x0000000000000001, word14=0, word15=0, t=0, blk_last=1.
- One byte 0xCC -> word0=0xCC80000000000000, word13=0x01, word15=8, t=8, blk_last=1; blk_valid 2 cycles after the transfer.
- 111 bytes -> single block; byte 111 = 0x81 (word13 low byte), word15=888, t=888.
- 112 bytes -> block1: word14=0x8000000000000000, word15=0, t=896, blk_last=0. After core_done, block2: word0=0, word13=0x01, word15=896, t=0, blk_last=1.
- 128 bytes (16 full words, last flagged) -> block1 raw data, t=1024, no padding. Block2: word0=0x8000000000000000, word13=0x01, word15=1024, t=0. in_ready=0 throughout WAIT.
- rst asserted in WAIT of a first block of 256 bytes -> outputs zero, state FILL. A following core_done is ignored; a new 1-byte message yields t=8.

Source files
------------

// File: rtl/blake512_pkg.sv
// Shared constants for the BLAKE-512 message loader: block geometry, padding bytes,
// FSM state encoding and small word helpers.
package blake512_pkg;

  localparam int BLK_W       = 1024;
  localparam int WORD_W      = 64;
  localparam int BLK_NWORDS  = 16;
  localparam int BLK_BYTES   = 128;

  localparam logic [7:0] PAD_MARKER = 8'h80;
  localparam logic [7:0] PAD_TERM   = 8'h01;
  localparam int TERM_BYTE   = 111;
  localparam int LEN_WORD_HI = 14;
  localparam int LEN_WORD_LO = 15;

  localparam logic [2:0] ST_FILL  = 3'd0;
  localparam logic [2:0] ST_PAD   = 3'd1;
  localparam logic [2:0] ST_PAD2  = 3'd2;
  localparam logic [2:0] ST_ISSUE = 3'd3;
  localparam logic [2:0] ST_WAIT  = 3'd4;

  // Where WAIT goes once the core finishes the block currently on the outputs
  localparam logic [1:0] NXT_FILL_NEW  = 2'd0;
  localparam logic [1:0] NXT_FILL_CONT = 2'd1;
  localparam logic [1:0] NXT_PAD2      = 2'd2;

  function automatic logic [WORD_W-1:0] byte_swap64(input logic [WORD_W-1:0] w);
    logic [WORD_W-1:0] r;
    for (int j = 0; j < 8; j++) begin
      r[WORD_W-1-8*j -: 8] = w[8*j +: 8];
    end
    return r;
  endfunction

  function automatic logic [WORD_W-1:0] mask_tail(input logic [WORD_W-1:0] w,
                                                  input logic [3:0] nbytes);
    logic [WORD_W-1:0] r;
    r = w;
    for (int j = 0; j < 8; j++) begin
      if (j >= int'(nbytes)) begin
        r[WORD_W-1-8*j -: 8] = 8'h00;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/blake512_pad_gen.sv
// Combinational BLAKE-512 padder: clears everything from byte b_off on, then optionally
// drops the 0x80 marker at b_off and the 0x01 terminator plus 128-bit bit length.
module blake512_pad_gen
  import blake512_pkg::*;
#(
  parameter int LEN_W = 64
) (
  input  logic [BLK_W-1:0] blk_in,
  input  logic [7:0]       b_off,
  input  logic [LEN_W-1:0] msg_len,
  input  logic             place_marker,
  input  logic             place_term,
  output logic [BLK_W-1:0] blk_out
);

  // Terminator is OR-ed after the marker so a message ending at byte 111 yields 0x81
  always_comb begin
    blk_out = blk_in;
    for (int i = 0; i < BLK_BYTES; i++) begin
      if (i >= int'(b_off)) begin
        blk_out[BLK_W-1-8*i -: 8] = 8'h00;
      end
    end
    if (place_marker && !b_off[7]) begin
      blk_out[{~b_off[6:0], 3'b000} +: 8] = PAD_MARKER;
    end
    if (place_term) begin
      blk_out[(BLK_BYTES-1-TERM_BYTE)*8 +: 8] =
        blk_out[(BLK_BYTES-1-TERM_BYTE)*8 +: 8] | PAD_TERM;
      blk_out[(BLK_NWORDS-LEN_WORD_HI)*WORD_W-1 : 0] = 128'(msg_len);
    end
  end

endmodule

// File: rtl/blake512_msg_loader.sv
// Buffers a 64-bit word stream into padded 1024-bit BLAKE-512 blocks and hands them to the core.
// Optional build macro LOADER_BSWAP_EN: accept little-endian words (byte-reversed on input).
module blake512_msg_loader
  import blake512_pkg::*;
#(
  parameter int LEN_W  = 64,
  parameter int NWORDS = BLK_NWORDS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_last,
  input  logic [3:0]        in_bytes,
  output logic              blk_valid,
  output logic [BLK_W-1:0]  blk_m,
  output logic [127:0]      blk_t,
  output logic              blk_last,
  input  logic              core_done,
  output logic              busy
);

  logic [2:0]        state;
  logic [3:0]        idx;
  logic [LEN_W-1:0]  msg_len;
  logic [7:0]        b_off;
  logic [1:0]        after_wait;
  logic              marker_placed;

  logic [WORD_W-1:0] word_in;
  logic [3:0]        nbytes;
  logic              xfer;
  logic [LEN_W-1:0]  len_plus_word;
  logic [LEN_W-1:0]  len_plus_tail;
  logic [7:0]        end_off;

  logic [7:0]        pad_off;
  logic              pad_marker;
  logic              pad_term;
  logic [BLK_W-1:0]  pad_blk;

`ifdef LOADER_BSWAP_EN
  assign word_in = byte_swap64(in_data);
`else
  assign word_in = in_data;
`endif

  // Out-of-range byte counts are treated as a full word
  assign nbytes        = (in_bytes > 4'd8) ? 4'd8 : in_bytes;
  assign xfer          = in_valid && in_ready;
  assign len_plus_word = msg_len + LEN_W'(WORD_W);
  assign len_plus_tail = msg_len + LEN_W'({nbytes, 3'b000});
  assign end_off       = {1'b0, idx, 3'b000} + {4'b0000, nbytes};

  assign in_ready  = (state == ST_FILL);
  assign busy      = (state != ST_FILL);
  assign blk_valid = (state == ST_ISSUE);

  always_comb begin
    pad_off    = b_off;
    pad_marker = !b_off[7];
    pad_term   = (b_off <= 8'(TERM_BYTE));
    if (state == ST_PAD2) begin
      pad_off    = 8'd0;
      pad_marker = !marker_placed;
      pad_term   = 1'b1;
    end
  end

  blake512_pad_gen #(
    .LEN_W(LEN_W)
  ) u_pad_gen (
    .blk_in      (blk_m),
    .b_off       (pad_off),
    .msg_len     (msg_len),
    .place_marker(pad_marker),
    .place_term  (pad_term),
    .blk_out     (pad_blk)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_FILL;
      idx           <= '0;
      msg_len       <= '0;
      b_off         <= '0;
      after_wait    <= NXT_FILL_NEW;
      marker_placed <= 1'b0;
      blk_m         <= '0;
      blk_t         <= '0;
      blk_last      <= 1'b0;
    end else begin
      case (state)
        ST_FILL: begin
          if (xfer) begin
            if (in_last) begin
              blk_m[{~idx, 6'b000000} +: WORD_W] <= mask_tail(word_in, nbytes);
              msg_len <= len_plus_tail;
              b_off   <= end_off;
              state   <= ST_PAD;
            end else begin
              blk_m[{~idx, 6'b000000} +: WORD_W] <= word_in;
              msg_len <= len_plus_word;
              idx     <= idx + 4'd1;
              if (idx == 4'(NWORDS-1)) begin
                blk_t      <= 128'(len_plus_word);
                blk_last   <= 1'b0;
                after_wait <= NXT_FILL_CONT;
                state      <= ST_ISSUE;
              end
            end
          end
        end
        // A block with no message bytes (message ended on a block boundary) carries t=0
        ST_PAD: begin
          blk_m         <= pad_blk;
          blk_t         <= (b_off != 8'd0) ? 128'(msg_len) : 128'd0;
          blk_last      <= pad_term;
          after_wait    <= pad_term ? NXT_FILL_NEW : NXT_PAD2;
          marker_placed <= pad_marker;
          state         <= ST_ISSUE;
        end
        ST_PAD2: begin
          blk_m      <= pad_blk;
          blk_t      <= '0;
          blk_last   <= 1'b1;
          after_wait <= NXT_FILL_NEW;
          state      <= ST_ISSUE;
        end
        ST_ISSUE: begin
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (core_done) begin
            case (after_wait)
              NXT_FILL_NEW: begin
                state   <= ST_FILL;
                idx     <= '0;
                msg_len <= '0;
              end
              NXT_FILL_CONT: begin
                state <= ST_FILL;
                idx   <= '0;
              end
              default: begin
                state <= ST_PAD2;
              end
            endcase
          end
        end
        default: begin
          state <= ST_FILL;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_blake512_msg_loader.sv
// Randomized bench for blake512_msg_loader: each message is padded byte-wise by a
// reference model and every issued block, counter and handshake is compared against it.
module tb_blake512_msg_loader;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [63:0]   in_data;
  logic          in_last;
  logic [3:0]    in_bytes;
  logic          blk_valid;
  logic [1023:0] blk_m;
  logic [127:0]  blk_t;
  logic          blk_last;
  logic          core_done;
  logic          busy;

  int errors = 0;
  int checks = 0;
  int msgId  = 0;
  int msgLen;
  int nBlocks;
  logic [7:0] msg[$];
  logic [7:0] padded[$];

  blake512_msg_loader dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_last  (in_last),
    .in_bytes (in_bytes),
    .blk_valid(blk_valid),
    .blk_m    (blk_m),
    .blk_t    (blk_t),
    .blk_last (blk_last),
    .core_done(core_done),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Padding straight from the algorithm: pad to a multiple of 128 bytes leaving room for
  // the 0x80 marker, the 0x01 terminator 17 bytes from the end, and the 128-bit bit count
  task automatic buildModel();
    int p;
    logic [127:0] bitLen;
    p = ((msgLen + 17 + 127) / 128) * 128;
    padded.delete();
    for (int i = 0; i < p; i++) padded.push_back((i < msgLen) ? msg[i] : 8'h00);
    padded[msgLen] = padded[msgLen] | 8'h80;
    padded[p-17]   = padded[p-17] | 8'h01;
    bitLen = 128'(msgLen) * 128'd8;
    for (int j = 0; j < 16; j++) padded[p-16+j] = bitLen[127-8*j -: 8];
    nBlocks = p / 128;
  endtask

  function automatic logic [63:0] expWord(input int k, input int w);
    logic [63:0] v;
    v = '0;
    for (int j = 0; j < 8; j++) v[63-8*j -: 8] = padded[128*k + 8*w + j];
    return v;
  endfunction

  function automatic logic [127:0] expT(input int k);
    int upto;
    if (128*k >= msgLen) return '0;
    upto = (msgLen < 128*(k+1)) ? msgLen : 128*(k+1);
    return 128'(upto) * 128'd8;
  endfunction

  // Bytes past nb are random junk that the loader must mask away
  function automatic logic [63:0] packWord(input int base, input int nb);
    logic [63:0] v;
    logic [7:0]  b;
    v = '0;
    for (int j = 0; j < 8; j++) begin
      b = (j < nb) ? msg[base+j] : 8'($urandom);
`ifdef LOADER_BSWAP_EN
      v[8*j +: 8] = b;
`else
      v[63-8*j -: 8] = b;
`endif
    end
    return v;
  endfunction

  task automatic applyStimulus(input logic [63:0] d, input logic last, input logic [3:0] nb);
    int guard;
    guard = 0;
    repeat ($urandom_range(0, 2)) @(negedge clk);
    while (!in_ready && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    checkOutput($sformatf("m%0d_in_ready", msgId), {127'b0, in_ready}, 128'd1);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    in_bytes = nb;
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = 64'($urandom);
    in_bytes = 4'($urandom);
  endtask

  task automatic collectBlock(input int k, input int expLat, input bit checkLat, input bit doRelease);
    int lat;
    lat = 0;
    while (!blk_valid && lat < 400) begin
      @(negedge clk);
      lat++;
    end
    checkOutput($sformatf("m%0d_b%0d_valid", msgId, k), {127'b0, blk_valid}, 128'd1);
    if (checkLat) checkOutput($sformatf("m%0d_b%0d_latency", msgId, k), 128'(lat), 128'(expLat));
    for (int w = 0; w < 16; w++)
      checkOutput($sformatf("m%0d_b%0d_w%0d", msgId, k, w), {64'b0, blk_m[1023-64*w -: 64]},
                  {64'b0, expWord(k, w)});
    checkOutput($sformatf("m%0d_b%0d_t", msgId, k), blk_t, expT(k));
    checkOutput($sformatf("m%0d_b%0d_last", msgId, k), {127'b0, blk_last},
                {127'b0, (k == nBlocks-1)});
    @(negedge clk);
    checkOutput($sformatf("m%0d_b%0d_pulse", msgId, k), {127'b0, blk_valid}, 128'd0);
    checkOutput($sformatf("m%0d_b%0d_wait_ready", msgId, k), {127'b0, in_ready}, 128'd0);
    checkOutput($sformatf("m%0d_b%0d_busy", msgId, k), {127'b0, busy}, 128'd1);
    if (doRelease) begin
      // Offer a junk word while the core runs; it must not be taken
      in_valid = 1'b1;
      repeat ($urandom_range(1, 10)) @(negedge clk);
      in_valid = 1'b0;
      checkOutput($sformatf("m%0d_b%0d_hold_w0", msgId, k), {64'b0, blk_m[1023:960]},
                  {64'b0, expWord(k, 0)});
      checkOutput($sformatf("m%0d_b%0d_hold_t", msgId, k), blk_t, expT(k));
      core_done = 1'b1;
      @(negedge clk);
      core_done = 1'b0;
    end
  endtask

  task automatic newMessage(input int len);
    msgId++;
    msgLen = len;
    msg.delete();
    for (int i = 0; i < len; i++) msg.push_back(8'($urandom));
    if (len == 1) msg[0] = 8'hCC;
    buildModel();
  endtask

  task automatic runMessage(input int len, input bit emptyTail);
    int nw;
    int nb;
    int blk;
    logic lastFlag;
    newMessage(len);
    blk = 0;
    if (len == 0) begin
      applyStimulus(packWord(0, 0), 1'b1, 4'd0);
    end else begin
      nw = (len + 7) / 8;
      for (int w = 0; w < nw; w++) begin
        nb = (w == nw-1) ? len - 8*w : 8;
        lastFlag = (w == nw-1) && !(emptyTail && nb == 8);
        applyStimulus(packWord(8*w, nb), lastFlag, lastFlag ? 4'(nb) : 4'($urandom));
        if (!lastFlag && (w % 16) == 15) begin
          collectBlock(blk, 0, 1'b1, 1'b1);
          blk++;
        end
      end
      if (emptyTail && (len % 8) == 0) applyStimulus(packWord(len, 0), 1'b1, 4'd0);
    end
    collectBlock(blk, 1, 1'b1, 1'b1);
    blk++;
    while (blk < nBlocks) begin
      collectBlock(blk, 1, 1'b0, 1'b1);
      blk++;
    end
    checkOutput($sformatf("m%0d_idle_busy", msgId), {127'b0, busy}, 128'd0);
    checkOutput($sformatf("m%0d_idle_ready", msgId), {127'b0, in_ready}, 128'd1);
  endtask

  task automatic resetInWait();
    bit seen;
    newMessage(256);
    for (int w = 0; w < 16; w++) applyStimulus(packWord(8*w, 8), 1'b0, 4'($urandom));
    collectBlock(0, 0, 1'b1, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("rstwait_valid", {127'b0, blk_valid}, 128'd0);
    checkOutput("rstwait_ready", {127'b0, in_ready}, 128'd1);
    checkOutput("rstwait_busy", {127'b0, busy}, 128'd0);
    checkOutput("rstwait_t", blk_t, 128'd0);
    checkOutput("rstwait_last", {127'b0, blk_last}, 128'd0);
    checkOutput("rstwait_m_nonzero", {127'b0, |blk_m}, 128'd0);
    core_done = 1'b1;
    @(negedge clk);
    core_done = 1'b0;
    seen = 1'b0;
    repeat (5) begin
      @(negedge clk);
      seen = seen | blk_valid | busy;
    end
    checkOutput("rstwait_stray_done", {127'b0, seen}, 128'd0);
    runMessage(1, 1'b0);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    in_data   = '0;
    in_bytes  = '0;
    core_done = 1'b0;
    $display("[TB] blake512_msg_loader bench starting");
    repeat (3) @(negedge clk);
    checkOutput("reset_valid", {127'b0, blk_valid}, 128'd0);
    checkOutput("reset_t", blk_t, 128'd0);
    checkOutput("reset_last", {127'b0, blk_last}, 128'd0);
    checkOutput("reset_m_nonzero", {127'b0, |blk_m}, 128'd0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("reset_ready", {127'b0, in_ready}, 128'd1);
    checkOutput("reset_busy", {127'b0, busy}, 128'd0);

    runMessage(0, 1'b0);
    runMessage(1, 1'b0);
    runMessage(111, 1'b0);
    runMessage(112, 1'b0);
    runMessage(128, 1'b0);
    runMessage(128, 1'b1);
    runMessage(8, 1'b1);
    runMessage(127, 1'b0);
    runMessage(256, 1'b0);
    resetInWait();
    for (int i = 0; i < 20; i++) runMessage($urandom_range(0, 300), 1'($urandom));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
